// File: rtl/pp_pipeline_accel_fifo_to_axis_if.sv
// AXI4-Stream style output bundle for the FIFO-to-stream frame pump.
interface pp_pipeline_accel_fifo_to_axis_if #(
  parameter int unsigned DATA_WIDTH = 64
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic                  tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/pp_pipeline_accel_fifo_to_axis.sv
// Pops a cfg_words x cfg_lines frame from a show-ahead FIFO onto an AXI stream (tlast per line,
// tuser on first beat). Define PP_PIPELINE_ACCEL_FIFO_TO_AXIS_STALL_CNT_EN to add stall_cnt.
module pp_pipeline_accel_fifo_to_axis #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  cfg_words,
  input  logic [CNT_WIDTH-1:0]  cfg_lines,
  output logic                  busy,
  output logic                  done,
  input  logic                  if_empty_n,
  input  logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_read,
  pp_pipeline_accel_fifo_to_axis_if.master m_axis
`ifdef PP_PIPELINE_ACCEL_FIFO_TO_AXIS_STALL_CNT_EN
  ,
  output logic [31:0]           stall_cnt
`endif
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  words_q, lines_q;
  logic [CNT_WIDTH-1:0]  word_cnt_q, line_cnt_q;
  logic                  popped_all_q;
  logic [DATA_WIDTH-1:0] tdata_q;
  logic                  tvalid_q, tlast_q, tuser_q, tfinal_q;

  logic start_ok, cfg_zero, pop, hs, word_wrap, line_end;

  assign start_ok  = (state_q == StIdle) && start;
  assign cfg_zero  = (cfg_words == '0) || (cfg_lines == '0);
  assign hs        = tvalid_q && m_axis.tready;
  assign word_wrap = (word_cnt_q == words_q - CNT_WIDTH'(1));
  assign line_end  = (line_cnt_q == lines_q - CNT_WIDTH'(1));
  // Gated by reset so no FIFO word is lost during a reset cycle.
  assign pop = !reset && (state_q == StRun) && if_empty_n && !popped_all_q &&
               (!tvalid_q || m_axis.tready);

  assign if_read       = pop;
  assign busy          = (state_q != StIdle);
  assign done          = (state_q == StDone);
  assign m_axis.tdata  = tdata_q;
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tlast  = tlast_q;
  assign m_axis.tuser  = tuser_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = cfg_zero ? StDone : StRun;
      StRun:   if (hs && tfinal_q) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      words_q      <= '0;
      lines_q      <= '0;
      word_cnt_q   <= '0;
      line_cnt_q   <= '0;
      popped_all_q <= 1'b0;
      tdata_q      <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      tuser_q      <= 1'b0;
      tfinal_q     <= 1'b0;
    end else begin
      if (start_ok) begin
        words_q      <= cfg_words;
        lines_q      <= cfg_lines;
        word_cnt_q   <= '0;
        line_cnt_q   <= '0;
        popped_all_q <= 1'b0;
      end
      if (pop) begin
        tdata_q    <= if_dout;
        tvalid_q   <= 1'b1;
        tlast_q    <= word_wrap;
        tuser_q    <= (word_cnt_q == '0) && (line_cnt_q == '0);
        tfinal_q   <= word_wrap && line_end;
        word_cnt_q <= word_wrap ? '0 : word_cnt_q + CNT_WIDTH'(1);
        if (word_wrap) line_cnt_q <= line_cnt_q + CNT_WIDTH'(1);
        if (word_wrap && line_end) popped_all_q <= 1'b1;
      end else if (hs) begin
        tvalid_q <= 1'b0;
        tlast_q  <= 1'b0;
        tuser_q  <= 1'b0;
        tfinal_q <= 1'b0;
      end
    end
  end

`ifdef PP_PIPELINE_ACCEL_FIFO_TO_AXIS_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset || start_ok) begin
      stall_cnt <= '0;
    end else if ((state_q == StRun) && tvalid_q && !m_axis.tready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pp_pipeline_accel_fifo_to_axis.sv
// Table-driven frame tests with a scoreboard of expected beats built when the FIFO is filled.
module tb_pp_pipeline_accel_fifo_to_axis;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [15:0] cfg_words, cfg_lines;
  logic        busy, done, if_empty_n, if_read;
  logic [63:0] if_dout;
`ifdef PP_PIPELINE_ACCEL_FIFO_TO_AXIS_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  pp_pipeline_accel_fifo_to_axis_if #(.DATA_WIDTH(64)) m_axis ();

  pp_pipeline_accel_fifo_to_axis #(.DATA_WIDTH(64), .CNT_WIDTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .cfg_words  (cfg_words),
    .cfg_lines  (cfg_lines),
    .busy       (busy),
    .done       (done),
    .if_empty_n (if_empty_n),
    .if_dout    (if_dout),
    .if_read    (if_read),
    .m_axis     (m_axis)
`ifdef PP_PIPELINE_ACCEL_FIFO_TO_AXIS_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // FIFO model: show-ahead head word, pop on if_read at the clock edge.
  logic [63:0] mem [64];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          read_cnt = 0;
  logic        fifo_hold = 1'b0;
  logic        fifo_flush = 1'b0;

  assign if_empty_n = (wr_ptr != rd_ptr) && !fifo_hold;
  assign if_dout    = mem[rd_ptr[5:0]];

  always @(posedge clk) begin
    if (fifo_flush) rd_ptr <= wr_ptr;
    else if (if_read) rd_ptr <= rd_ptr + 1;
    if (if_read) read_cnt <= read_cnt + 1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
    logic        user;
  } beat_t;
  beat_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int beats    = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int last_hs  = 0;
  int stall_seen = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output monitor: every valid beat is compared with the scoreboard head (held beats too).
  always @(negedge clk) begin
    if (!reset) begin
      if (m_axis.tvalid) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got data %0h with no expected beat", m_axis.tdata);
        end else begin
          chk("beat_data", m_axis.tdata, sb[0].data);
          chk("beat_tlast", m_axis.tlast, sb[0].last);
          chk("beat_tuser", m_axis.tuser, sb[0].user);
          if (m_axis.tready) begin
            void'(sb.pop_front());
            beats++;
            last_hs = cyc;
          end
        end
        if (busy && !m_axis.tready) stall_seen++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (!if_empty_n) chk("read_while_empty", if_read, 1'b0);
    end
  end

  task automatic push_frame(input int words, input int lines);
    for (int l = 0; l < lines; l++) begin
      for (int w = 0; w < words; w++) begin
        beat_t b;
        b.data = {$urandom, $urandom};
        b.last = (w == words - 1);
        b.user = (l == 0) && (w == 0);
        mem[wr_ptr % 64] = b.data;
        wr_ptr++;
        sb.push_back(b);
      end
    end
  endtask

  typedef struct {
    int words;
    int lines;
    int mode;       // tready: 0 always, 1 toggle, 2 random
    bit gap;        // hold FIFO empty 5 cycles after word 2
    bit mid_start;  // pulse start with other cfg during RUN
    int exp_beats;
  } vec_t;

  task automatic run_frame(input vec_t v);
    int base_reads, base_beats, base_done, gap_cycles, iter;
    base_reads = read_cnt;
    base_beats = beats;
    base_done  = done_cnt;
    if (v.words * v.lines > 0) push_frame(v.words, v.lines);
    @(posedge clk); #1;
    stall_seen = 0;
    start = 1'b1;
    cfg_words = 16'(v.words);
    cfg_lines = 16'(v.lines);
    m_axis.tready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    iter = 0;
    gap_cycles = 0;
    while (done_cnt == base_done && iter < 400) begin
      case (v.mode)
        0:       m_axis.tready = 1'b1;
        1:       m_axis.tready = iter[0];
        default: m_axis.tready = 1'($urandom_range(0, 1));
      endcase
      if (v.mid_start && iter == 3) begin
        start = 1'b1;
        cfg_words = 16'd1;
        cfg_lines = 16'd1;
      end else begin
        start = 1'b0;
      end
      if (v.gap && (read_cnt - base_reads == 3) && gap_cycles < 5) begin
        fifo_hold = 1'b1;
        gap_cycles++;
        if (gap_cycles >= 2) chk("gap_tvalid_low", m_axis.tvalid, 1'b0);
      end else begin
        fifo_hold = 1'b0;
      end
      @(posedge clk); #1;
      iter++;
    end
    fifo_hold = 1'b0;
    start = 1'b0;
    m_axis.tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("done_pulses", done_cnt - base_done, 1);
    chk("beat_count", beats - base_beats, v.exp_beats);
    chk("fifo_reads", read_cnt - base_reads, v.exp_beats);
    chk("sb_empty", sb.size(), 0);
    chk("idle_after", busy, 1'b0);
    if (v.gap) chk("gap_length", gap_cycles, 5);
    if (v.exp_beats > 0) chk("done_latency", done_cyc, last_hs + 1);
`ifdef PP_PIPELINE_ACCEL_FIFO_TO_AXIS_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, stall_seen);
`endif
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{words: 4, lines: 2, mode: 0, gap: 0, mid_start: 0, exp_beats: 8};
    vecs[1] = '{words: 4, lines: 2, mode: 1, gap: 0, mid_start: 0, exp_beats: 8};
    vecs[2] = '{words: 4, lines: 2, mode: 0, gap: 1, mid_start: 0, exp_beats: 8};
    vecs[3] = '{words: 0, lines: 3, mode: 0, gap: 0, mid_start: 0, exp_beats: 0};
    vecs[4] = '{words: 3, lines: 0, mode: 0, gap: 0, mid_start: 0, exp_beats: 0};
    vecs[5] = '{words: 4, lines: 2, mode: 0, gap: 0, mid_start: 1, exp_beats: 8};
    vecs[6] = '{words: 1, lines: 5, mode: 2, gap: 0, mid_start: 0, exp_beats: 5};
    vecs[7] = '{words: 5, lines: 3, mode: 2, gap: 0, mid_start: 0, exp_beats: 15};
    vecs[8] = '{words: 1, lines: 1, mode: 0, gap: 0, mid_start: 0, exp_beats: 1};

    reset = 1'b1;
    start = 1'b0;
    cfg_words = '0;
    cfg_lines = '0;
    m_axis.tready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_if_read", if_read, 1'b0);
    chk("rst_tvalid", m_axis.tvalid, 1'b0);
    chk("rst_tlast", m_axis.tlast, 1'b0);
    chk("rst_tuser", m_axis.tuser, 1'b0);
    chk("rst_tdata", m_axis.tdata, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 9; i++) run_frame(vecs[i]);

    // Reset after beat 2 of a 4x2 frame, then a clean frame.
    push_frame(4, 2);
    @(posedge clk); #1;
    start = 1'b1;
    cfg_words = 16'd4;
    cfg_lines = 16'd2;
    @(posedge clk); #1;
    start = 1'b0;
    begin
      int base_beats, guard;
      base_beats = beats - 0;
      guard = 0;
      while (beats < base_beats + 3 && guard < 100) begin
        @(posedge clk); #1;
        guard++;
      end
      chk("pre_reset_beats", beats - base_beats, 3);
    end
    reset = 1'b1;
    fifo_flush = 1'b1;
    @(negedge clk);
    chk("reset_cycle_no_pop", if_read, 1'b0);
    @(negedge clk);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_tvalid", m_axis.tvalid, 1'b0);
    chk("mid_rst_tlast", m_axis.tlast, 1'b0);
    chk("mid_rst_tuser", m_axis.tuser, 1'b0);
    chk("mid_rst_tdata", m_axis.tdata, 64'd0);
    chk("mid_rst_done", done, 1'b0);
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    fifo_flush = 1'b0;
    run_frame(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
